// File: rtl/tm_pkg.sv
// Shared definitions for the PCM telemetry serializer: field widths,
// FSM state encoding and the odd-parity helper used at capture.
package tm_pkg;

  localparam int TAG_W  = 8;
  localparam int RTR_W  = 5;
  localparam int DATA_W = 26;
  localparam int WORD_W = TAG_W + RTR_W + DATA_W + 1;
  localparam int CNT_W  = $clog2(WORD_W + 1);

  typedef enum logic {
    TM_IDLE  = 1'b0,
    TM_SHIFT = 1'b1
  } tm_state_e;

  // Parity bit that makes the total count of ones (payload + P) odd.
  function automatic logic tm_odd_parity(input logic [WORD_W-2:0] payload);
    return ~(^payload);
  endfunction

endpackage

// File: rtl/tm_pcm_serializer_if.sv
// Load/telemetry bundle between the register side and the serializer.
// Handshake: LOAD is a one-cycle strobe with no back-pressure; a LOAD that
// cannot be held is dropped and reported on the sticky OVF flag. BIT_EN
// is a one-cycle bit-time enable. TMSYNC pulses once per word start.
interface tm_pcm_serializer_if;
  import tm_pkg::*;

  logic              LOAD;
  logic [TAG_W-1:0]  TAG;
  logic [RTR_W-1:0]  RTR;
  logic [DATA_W-1:0] DATA;
  logic              BIT_EN;
  logic              OVF_CLR;
  logic              TMD;
  logic              TMSYNC;
  logic              BUSY;
  logic              HOLD_FULL;
  logic              OVF;
  tm_state_e         state_dbg;

  modport master (
    output LOAD, TAG, RTR, DATA, BIT_EN, OVF_CLR,
    input  TMD, TMSYNC, BUSY, HOLD_FULL, OVF, state_dbg
  );

  modport slave (
    input  LOAD, TAG, RTR, DATA, BIT_EN, OVF_CLR,
    output TMD, TMSYNC, BUSY, HOLD_FULL, OVF, state_dbg
  );

endinterface

// File: rtl/tm_hold_buf.sv
// Single-entry holding register. Frames TAG/RTR/DATA with odd parity on
// capture, hands the word to the shifter on xfer, and flags dropped loads.
module tm_hold_buf
  import tm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TAG_W-1:0]  tag,
  input  logic [RTR_W-1:0]  rtr,
  input  logic [DATA_W-1:0] data,
  input  logic              xfer,
  input  logic              ovf_clr,
  output logic              valid,
  output logic [WORD_W-1:0] word,
  output logic              ovf
);

  logic              accept;
  logic [WORD_W-2:0] payload;

  // A load fits if the slot is empty or is being vacated this same cycle.
  always_comb begin
    payload = {tag, rtr, data};
    accept  = load & (~valid | xfer);
  end

  // Slot contents and occupancy; a new capture overrides the vacate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      word  <= '0;
    end else if (accept) begin
      valid <= 1'b1;
      word  <= {payload, tm_odd_parity(payload)};
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (load & ~accept) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/tm_pcm_serializer.sv
// PCM telemetry serializer: takes framed words from the holding buffer and
// shifts them out MSB first, one bit per BIT_EN, reloading back-to-back
// on the final bit when another word is waiting.
module tm_pcm_serializer
  import tm_pkg::*;
(
  input  logic SIM_CLK,
  input  logic SIM_RST,
  tm_pcm_serializer_if.slave bus
);

  tm_state_e         state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmd_q, tmd_d;
  logic              sync_q;
  logic              xfer;
  logic              hb_valid;
  logic [WORD_W-1:0] hb_word;
  logic              hb_ovf;

  tm_hold_buf u_hold_buf (
    .clk     (SIM_CLK),
    .rst_n   (SIM_RST),
    .load    (bus.LOAD),
    .tag     (bus.TAG),
    .rtr     (bus.RTR),
    .data    (bus.DATA),
    .xfer    (xfer),
    .ovf_clr (bus.OVF_CLR),
    .valid   (hb_valid),
    .word    (hb_word),
    .ovf     (hb_ovf)
  );

  // Next-state, shifter and transfer decode; TMD is precomputed so the
  // output pin comes straight from a flop.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    xfer    = 1'b0;
    unique case (state_q)
      TM_IDLE: begin
        if (hb_valid) begin
          xfer    = 1'b1;
          shreg_d = hb_word;
          cnt_d   = CNT_W'(WORD_W);
          state_d = TM_SHIFT;
        end
      end
      TM_SHIFT: begin
        if (bus.BIT_EN) begin
          if (cnt_q == CNT_W'(1)) begin
            if (hb_valid) begin
              // Final bit done: next word starts with no gap bit.
              xfer    = 1'b1;
              shreg_d = hb_word;
              cnt_d   = CNT_W'(WORD_W);
            end else begin
              shreg_d = '0;
              cnt_d   = '0;
              state_d = TM_IDLE;
            end
          end else begin
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = TM_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
    tmd_d = (state_d == TM_SHIFT) ? shreg_d[WORD_W-1] : 1'b0;
  end

  // State, shifter, bit counter and registered outputs.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_q <= TM_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      tmd_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tmd_q   <= tmd_d;
      sync_q  <= xfer;
    end
  end

  assign bus.TMD       = tmd_q;
  assign bus.TMSYNC    = sync_q;
  assign bus.BUSY      = (state_q == TM_SHIFT) | hb_valid;
  assign bus.HOLD_FULL = hb_valid;
  assign bus.OVF       = hb_ovf;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_tm_pcm_serializer.sv
// Directed bench for tm_pcm_serializer: single word, parity, back-to-back,
// overrun, 40th-bit load boundary and mid-word reset.
module tb_tm_pcm_serializer;
  import tm_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [39:0] rx_w;
  logic        rx_sync;
  logic [39:0] w_a, w_b, w_c, w_d, w_g, w_h, w_i, w_l;

  tm_pcm_serializer_if ifc ();

  tm_pcm_serializer dut (
    .SIM_CLK (clk),
    .SIM_RST (rst_n),
    .bus     (ifc.slave)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference framing: {TAG, RTR, DATA, P} with P giving an odd count of ones.
  function automatic logic [39:0] frame(input logic [7:0] t, input logic [4:0] r,
                                        input logic [25:0] d);
    logic [38:0] p;
    p = {t, r, d};
    return {p, ~(^p)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle LOAD strobe (no BIT_EN in that cycle).
  task automatic do_load(input logic [7:0] t, input logic [4:0] r, input logic [25:0] d);
    ifc.LOAD = 1'b1;
    ifc.TAG  = t;
    ifc.RTR  = r;
    ifc.DATA = d;
    tick();
    ifc.LOAD = 1'b0;
  endtask

  // Sample TMD, pulse BIT_EN, note TMSYNC after the pulse, then one idle cycle.
  task automatic rx_bits(input int n);
    for (int i = 0; i < n; i++) begin
      rx_w = {rx_w[38:0], ifc.TMD};
      ifc.BIT_EN = 1'b1;
      tick();
      ifc.BIT_EN = 1'b0;
      rx_sync = ifc.TMSYNC;
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rx_w = '0;
    rx_sync = 1'b0;
    ifc.LOAD = 1'b0;
    ifc.TAG = '0;
    ifc.RTR = '0;
    ifc.DATA = '0;
    ifc.BIT_EN = 1'b0;
    ifc.OVF_CLR = 1'b0;

    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_tmd", {39'd0, ifc.TMD}, 40'd0);
    chk("rst_tmsync", {39'd0, ifc.TMSYNC}, 40'd0);
    chk("rst_busy", {39'd0, ifc.BUSY}, 40'd0);
    chk("rst_hold_full", {39'd0, ifc.HOLD_FULL}, 40'd0);
    chk("rst_ovf", {39'd0, ifc.OVF}, 40'd0);
    rst_n = 1'b1;
    tick();

    // Single word: A5 / 13 / 0 -> 7 ones, P = 0
    do_load(8'hA5, 5'h13, 26'h0);
    chk("t1_hb_full_n1", {39'd0, ifc.HOLD_FULL}, 40'd1);
    chk("t1_sync_n1", {39'd0, ifc.TMSYNC}, 40'd0);
    chk("t1_busy_n1", {39'd0, ifc.BUSY}, 40'd1);
    tick();
    chk("t1_sync_n2", {39'd0, ifc.TMSYNC}, 40'd1);
    chk("t1_tmd_first", {39'd0, ifc.TMD}, 40'd1);
    chk("t1_hb_empty_n2", {39'd0, ifc.HOLD_FULL}, 40'd0);
    rx_w = '0;
    rx_bits(1);
    chk("t1_sync_one_cycle", {39'd0, ifc.TMSYNC}, 40'd0);
    rx_bits(39);
    chk("t1_word", rx_w, 40'hA5_9800_0000);
    chk("t1_idle_tmd", {39'd0, ifc.TMD}, 40'd0);
    chk("t1_idle_busy", {39'd0, ifc.BUSY}, 40'd0);
    // BIT_EN in IDLE must not start anything
    ifc.BIT_EN = 1'b1;
    tick();
    ifc.BIT_EN = 1'b0;
    chk("t1_bit_en_idle", {38'd0, ifc.BUSY, ifc.TMSYNC}, 40'd0);

    // Parity: DATA=1 -> P=0 ; DATA=0 -> P=1
    do_load(8'h00, 5'h00, 26'h1);
    tick();
    rx_w = '0;
    rx_bits(40);
    chk("par1_word", rx_w, 40'h00_0000_0002);
    chk("par1_p", {39'd0, rx_w[0]}, 40'd0);
    do_load(8'h00, 5'h00, 26'h0);
    tick();
    rx_w = '0;
    rx_bits(40);
    chk("par0_word", rx_w, 40'h00_0000_0001);
    chk("par0_p", {39'd0, rx_w[0]}, 40'd1);

    // Back-to-back: second LOAD mid-word, reload with no gap bit
    w_a = frame(8'h3C, 5'h0A, 26'h2AA_AAAA);
    w_b = frame(8'hC3, 5'h15, 26'h155_5555);
    do_load(8'h3C, 5'h0A, 26'h2AA_AAAA);
    tick();
    rx_w = '0;
    rx_bits(5);
    do_load(8'hC3, 5'h15, 26'h155_5555);
    chk("b2b_hold_full", {39'd0, ifc.HOLD_FULL}, 40'd1);
    rx_bits(35);
    chk("b2b_word_a", rx_w, w_a);
    chk("b2b_reload_sync", {39'd0, rx_sync}, 40'd1);
    chk("b2b_first_b", {39'd0, ifc.TMD}, {39'd0, w_b[39]});
    rx_w = '0;
    rx_bits(40);
    chk("b2b_word_b", rx_w, w_b);
    chk("b2b_idle_busy", {39'd0, ifc.BUSY}, 40'd0);

    // Overrun: third LOAD dropped, OVF sticky, clear+load keeps OVF set
    w_c = frame(8'h12, 5'h01, 26'h000_1234);
    w_d = frame(8'h81, 5'h1F, 26'h3FF_0000);
    do_load(8'h12, 5'h01, 26'h000_1234);
    tick();
    rx_w = '0;
    rx_bits(3);
    do_load(8'h81, 5'h1F, 26'h3FF_0000);
    chk("ovr_no_ovf_yet", {39'd0, ifc.OVF}, 40'd0);
    do_load(8'hFF, 5'h00, 26'h000_00FF);
    chk("ovr_ovf_set", {39'd0, ifc.OVF}, 40'd1);
    chk("ovr_hold_full", {39'd0, ifc.HOLD_FULL}, 40'd1);
    ifc.OVF_CLR = 1'b1;
    do_load(8'h55, 5'h05, 26'h055_5555);
    ifc.OVF_CLR = 1'b0;
    chk("ovr_set_wins", {39'd0, ifc.OVF}, 40'd1);
    ifc.OVF_CLR = 1'b1;
    tick();
    ifc.OVF_CLR = 1'b0;
    chk("ovr_cleared", {39'd0, ifc.OVF}, 40'd0);
    rx_bits(37);
    chk("ovr_word_c", rx_w, w_c);
    chk("ovr_reload_sync", {39'd0, rx_sync}, 40'd1);
    rx_w = '0;
    rx_bits(40);
    chk("ovr_word_d", rx_w, w_d);
    chk("ovr_idle_busy", {39'd0, ifc.BUSY}, 40'd0);

    // Boundary: LOAD on the 40th BIT_EN with HB full is accepted
    w_g = frame(8'h01, 5'h02, 26'h000_0003);
    w_h = frame(8'h04, 5'h05, 26'h000_0006);
    w_i = frame(8'h07, 5'h08, 26'h000_0009);
    do_load(8'h01, 5'h02, 26'h000_0003);
    tick();
    rx_w = '0;
    rx_bits(2);
    do_load(8'h04, 5'h05, 26'h000_0006);
    rx_bits(37);
    rx_w = {rx_w[38:0], ifc.TMD};
    ifc.LOAD = 1'b1;
    ifc.TAG = 8'h07;
    ifc.RTR = 5'h08;
    ifc.DATA = 26'h000_0009;
    ifc.BIT_EN = 1'b1;
    tick();
    ifc.LOAD = 1'b0;
    ifc.BIT_EN = 1'b0;
    chk("bnd_word_g", rx_w, w_g);
    chk("bnd_sync", {39'd0, ifc.TMSYNC}, 40'd1);
    chk("bnd_no_ovf", {39'd0, ifc.OVF}, 40'd0);
    chk("bnd_hold_full", {39'd0, ifc.HOLD_FULL}, 40'd1);
    tick();
    rx_w = '0;
    rx_bits(40);
    chk("bnd_word_h", rx_w, w_h);
    chk("bnd_reload_sync", {39'd0, rx_sync}, 40'd1);
    rx_w = '0;
    rx_bits(40);
    chk("bnd_word_i", rx_w, w_i);
    chk("bnd_idle_busy", {39'd0, ifc.BUSY}, 40'd0);

    // Reset at bit 17 with a word pending in HB
    do_load(8'hF0, 5'h0F, 26'h0F0_F0F0);
    tick();
    rx_w = '0;
    rx_bits(10);
    do_load(8'h0F, 5'h10, 26'h30F_0F0F);
    rx_bits(7);
    rst_n = 1'b0;
    #1;
    chk("mrst_tmd", {39'd0, ifc.TMD}, 40'd0);
    chk("mrst_tmsync", {39'd0, ifc.TMSYNC}, 40'd0);
    chk("mrst_busy", {39'd0, ifc.BUSY}, 40'd0);
    chk("mrst_hold_full", {39'd0, ifc.HOLD_FULL}, 40'd0);
    chk("mrst_ovf", {39'd0, ifc.OVF}, 40'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    ifc.BIT_EN = 1'b1;
    tick();
    tick();
    ifc.BIT_EN = 1'b0;
    tick();
    chk("post_rst_quiet", {37'd0, ifc.TMD, ifc.TMSYNC, ifc.BUSY}, 40'd0);
    w_l = frame(8'h6B, 5'h19, 26'h1B2_C3D4);
    do_load(8'h6B, 5'h19, 26'h1B2_C3D4);
    tick();
    chk("post_rst_sync", {39'd0, ifc.TMSYNC}, 40'd1);
    rx_w = '0;
    rx_bits(40);
    chk("post_rst_word", rx_w, w_l);
    chk("post_rst_idle", {38'd0, ifc.TMD, ifc.BUSY}, 40'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tm_pcm_serializer.md
# tm_pcm_serializer

Downstream consumer of the LVDA tag and real-time telemetry registers. On a load strobe it captures the 8-bit tag (TAGR1–TAGR8), the 5-bit real-time register (RTR1–RTR5) and a 26-bit data word. It frames these with odd parity into a 40-bit PCM telemetry word and shifts the word out serially, MSB first, at the telemetry bit-enable rate. One word of holding buffer allows the next load to arrive while the current word is still shifting.

## Interface
- TAG_W, 8, tag field width (TAGR1 = MSB)
- RTR_W, 5, real-time register field width (RTR1 = MSB)
- DATA_W, 26, data field width
- WORD_W, TAG_W+RTR_W+DATA_W+1 = 40, framed word width (derived; not overridable)

Ports:
- SIM_CLK  in  1  sole clock
- SIM_RST  in  1  reset, asynchronous, active-low
- LOAD  in  1  one-cycle capture strobe for TAG/RTR/DATA
- TAG  in  TAG_W  {TAGR1..TAGR8}
- RTR  in  RTR_W  {RTR1..RTR5}
- DATA  in  DATA_W  data word, bit DATA_W-1 = MSB
- BIT_EN  in  1  one-cycle bit-time enable from the PCM clock divider
- OVF_CLR  in  1  clears OVF
- TMD  out  1  serial telemetry data
- TMSYNC  out  1  one-cycle pulse when a word is loaded into the shifter
- BUSY  out  1  shifter active or holding buffer full
- HOLD_FULL  out  1  holding buffer occupied
- OVF  out  1  sticky overrun: a LOAD was dropped

## Operation
- Word format, MSB first: TAG[7:0], RTR[4:0], DATA[25:0], P. P makes the count of ones across all 40 bits odd.
- Parity is computed combinationally at capture. It is stored in the holding buffer with the word.
- Holding buffer (HB): a LOAD is accepted if HB is empty, or if HB is transferring to the shifter in the same cycle. Otherwise the LOAD is dropped, OVF sets, and HB keeps its old contents.
- FSM states:
  - IDLE → LOAD: when HB is valid, the shifter takes HB, HB empties, bit count = 40, TMSYNC pulses, and the state goes to SHIFT.
  - SHIFT, on BIT_EN: shift left by one and decrement the count.
  - SHIFT, on the BIT_EN that drops the count to 0 (the 40th): if HB is valid, reload immediately (stay in SHIFT, pulse TMSYNC, no gap bit). Otherwise go to IDLE.
- TMD = shifter MSB while in SHIFT. TMD = 0 in IDLE.
- BUSY = (state == SHIFT) | HB valid.
- OVF: set on a dropped LOAD; cleared by OVF_CLR. If both occur in the same cycle, set wins.
- LOAD in IDLE with HB empty: capture to HB, transfer to the shifter on the following cycle.

## Timing
- Reset (SIM_RST low, asynchronous): state IDLE; TMD 0, TMSYNC 0, BUSY 0, HOLD_FULL 0, OVF 0; shifter, count and HB cleared.
- A reset mid-word abandons the word. No partial output follows release.
- Latency from a LOAD in IDLE:
  - cycle N+1: HB full
  - cycle N+2: shifter loaded, TMSYNC high, TMD = TAG[7]
- Each bit is held from one BIT_EN to the next. A word occupies exactly 40 BIT_EN pulses.
- BIT_EN is ignored in IDLE and in the cycle of a TMSYNC load. The first bit is held until the next BIT_EN after the load.
- Simultaneous events:
  - LOAD in the same cycle as the HB→shifter transfer: accepted, HB stays full.
  - LOAD with BIT_EN on the 40th bit and HB full: accepted, because HB frees that cycle.
- Outputs are registered, except BUSY, which is decoded from registers.

## Structure
- Shared package tm_pkg:
  - localparams TAG_W, RTR_W, DATA_W, WORD_W
  - state enum {TM_IDLE, TM_SHIFT}
  - function tm_odd_parity(word)
- One sub-module, tm_hold_buf: single-entry holding register with accept/transfer/overflow logic. The FSM and shifter stay in the top level.

## Test plan
- Single word: TAG=8'hA5, RTR=5'h13, DATA=0 gives 7 ones, so P=0. Bench checks TMSYNC 2 cycles after LOAD, then 40 BIT_EN bits = A5, 13, 26'h0, 0 MSB first, then IDLE with TMD=0 and BUSY=0.
- Parity: TAG=8'h00, RTR=0, DATA=26'h1 gives P=0. DATA=0 gives P=1. The last bit is checked in each case.
- Back-to-back: a second LOAD during word 1. Word 2's first bit must follow word 1's P on the very next BIT_EN, with TMSYNC at the reload and no gap.
- Overrun: three LOADs while shifting. The third is dropped, OVF=1, and the second word is transmitted intact. OVF_CLR and LOAD in the same cycle leave OVF=1.
- Boundary: a LOAD coinciding with the 40th BIT_EN while HB is full is accepted with no OVF. Three words are output in order.
- Reset: assert SIM_RST at bit 17. All outputs go to 0 immediately. After release, a fresh LOAD produces a full correct word.
